cpu_run_ctrl: RTL and testbench

//  Run/step/breakpoint controller for the KLP32 core on the board top level.
//  It converts the divided-clock tick into per-instruction enable pulses (o_cpuEn).
//  It supports free-run, single-step, operator halt and one PC breakpoint.
//  It also counts retired instructions for display or debug.

---
 rtl/cpu_run_ctrl.sv | 132 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt/breakpoint controller for the KLP32 core.
// Turns the divider tick into single-cycle instruction enables and counts them.
//
// state | meaning
// HALT  | stopped by operator or reset; ticks are dropped
// RUN   | one o_cpuEn per tick until halt edge or breakpoint
// STEP  | one o_cpuEn on the next tick, then HALT or BRK
// BRK   | stopped before executing the breakpoint instruction; o_bpHit set
module cpu_run_ctrl #(
   parameter int CNT_W         = 32,
   parameter bit START_RUNNING = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_tick,
   input  logic             i_run,
   input  logic             i_step,
   input  logic             i_halt,
   input  logic             i_bpEn,
   input  logic [31:0]      i_bpAddr,
   input  logic [31:0]      i_pc,
   output logic             o_cpuEn,
   output logic [1:0]       o_state,
   output logic             o_halted,
   output logic             o_bpHit,
   output logic [CNT_W-1:0] o_stepCount
);

   localparam logic [1:0] ST_HALT  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_STEP  = 2'b10;
   localparam logic [1:0] ST_BRK   = 2'b11;
   localparam logic [1:0] ST_RESET = START_RUNNING ? ST_RUN : ST_HALT;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_run_q;
   logic             r_step_q;
   logic             r_halt_q;
   logic             r_step_done;
   logic             r_bp_chk;
   logic             r_cpu_en;
   logic             r_bp_hit;
   logic             w_bp_hit_nxt;
   logic [CNT_W-1:0] r_step_count;
   logic             w_run_edge;
   logic             w_step_edge;
   logic             w_halt_edge;
   logic             w_bp_match;
   logic             w_cpu_en_nxt;

   assign w_run_edge  = i_run  & ~r_run_q;
   assign w_step_edge = i_step & ~r_step_q;
   assign w_halt_edge = i_halt & ~r_halt_q;

   // PC is only compared the cycle after a pulse, once the core has moved on
   assign w_bp_match   = r_bp_chk & i_bpEn & (i_pc == i_bpAddr);
   assign w_cpu_en_nxt = i_tick & ((r_state == ST_RUN) |
                                   ((r_state == ST_STEP) & ~r_step_done));

   always_comb begin
      w_state_nxt  = r_state;
      w_bp_hit_nxt = r_bp_hit;
      case (r_state)
         ST_HALT, ST_BRK: begin
            if (w_run_edge) begin
               w_state_nxt  = ST_RUN;
               w_bp_hit_nxt = 1'b0;
            end else if (w_step_edge) begin
               w_state_nxt  = ST_STEP;
               w_bp_hit_nxt = 1'b0;
            end
         end
         ST_RUN: begin
            if (w_halt_edge) begin
               w_state_nxt = ST_HALT;
            end else if (w_bp_match) begin
               w_state_nxt  = ST_BRK;
               w_bp_hit_nxt = 1'b1;
            end
         end
         ST_STEP: begin
            if (w_halt_edge) begin
               w_state_nxt = ST_HALT;
            end else if (r_step_done & r_bp_chk) begin
               if (w_bp_match) begin
                  w_state_nxt  = ST_BRK;
                  w_bp_hit_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_HALT;
               end
            end
         end
         default: w_state_nxt = ST_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_RESET;
         r_run_q      <= 1'b0;
         r_step_q     <= 1'b0;
         r_halt_q     <= 1'b0;
         r_step_done  <= 1'b0;
         r_bp_chk     <= 1'b0;
         r_cpu_en     <= 1'b0;
         r_bp_hit     <= 1'b0;
         r_step_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_run_q     <= i_run;
         r_step_q    <= i_step;
         r_halt_q    <= i_halt;
         r_cpu_en    <= w_cpu_en_nxt;
         r_bp_chk    <= r_cpu_en;
         r_bp_hit    <= w_bp_hit_nxt;
         // cleared on every entry to STEP since the previous state is never STEP
         r_step_done <= (r_state == ST_STEP) & (r_step_done | i_tick);
         if (r_cpu_en && (r_step_count != '1)) begin
            r_step_count <= r_step_count + CNT_ONE;
         end
      end
   end

   assign o_cpuEn     = r_cpu_en;
   assign o_state     = r_state;
   assign o_halted    = (r_state == ST_HALT) | (r_state == ST_BRK);
   assign o_bpHit     = r_bp_hit;
   assign o_stepCount = r_step_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: phase table with expected end-of-phase results,
// plus hand sequences for latency, coincident-event and reset corner cases.
module tb_cpu_run_ctrl;

   localparam logic [1:0] S_HALT = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_STEP = 2'b10;
   localparam logic [1:0] S_BRK  = 2'b11;

   localparam int OP_RESET   = 0;
   localparam int OP_TICKS   = 1;
   localparam int OP_RUN     = 2;
   localparam int OP_STEP    = 3;
   localparam int OP_HALT    = 4;
   localparam int OP_RUNSTEP = 5;

   typedef struct {
      int          op;
      int          arg;
      logic        bp_en;
      logic [31:0] bp_addr;
      logic [1:0]  st;
      int          pulses;
      int          cnt;
      int          cnt4;
      logic        hit;
      logic [31:0] pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_tick, i_run, i_step, i_halt, i_bpEn;
   logic [31:0] i_bpAddr;
   logic [31:0] pc;

   logic        o_cpuEn, o_halted, o_bpHit;
   logic [1:0]  o_state;
   logic [31:0] o_stepCount;
   logic        en4, halted4, hit4;
   logic [1:0]  state4;
   logic [3:0]  cnt4;
   logic        en_sr, halted_sr, hit_sr;
   logic [1:0]  state_sr;
   logic [31:0] cnt_sr;

   int n_vec = 0;
   int n_err = 0;
   int pulses = 0;
   int pulses4 = 0;

   vec_t tbl[$];
   vec_t exp_q[$];

   cpu_run_ctrl #(.CNT_W(32), .START_RUNNING(1'b0)) dut (
      .clk(clk), .reset(reset), .i_tick(i_tick), .i_run(i_run), .i_step(i_step),
      .i_halt(i_halt), .i_bpEn(i_bpEn), .i_bpAddr(i_bpAddr), .i_pc(pc),
      .o_cpuEn(o_cpuEn), .o_state(o_state), .o_halted(o_halted),
      .o_bpHit(o_bpHit), .o_stepCount(o_stepCount));

   cpu_run_ctrl #(.CNT_W(4), .START_RUNNING(1'b0)) dut4 (
      .clk(clk), .reset(reset), .i_tick(i_tick), .i_run(i_run), .i_step(i_step),
      .i_halt(i_halt), .i_bpEn(i_bpEn), .i_bpAddr(i_bpAddr), .i_pc(pc),
      .o_cpuEn(en4), .o_state(state4), .o_halted(halted4),
      .o_bpHit(hit4), .o_stepCount(cnt4));

   cpu_run_ctrl #(.CNT_W(32), .START_RUNNING(1'b1)) dut_sr (
      .clk(clk), .reset(reset), .i_tick(i_tick), .i_run(i_run), .i_step(i_step),
      .i_halt(i_halt), .i_bpEn(i_bpEn), .i_bpAddr(i_bpAddr), .i_pc(pc),
      .o_cpuEn(en_sr), .o_state(state_sr), .o_halted(halted_sr),
      .o_bpHit(hit_sr), .o_stepCount(cnt_sr));

   always #5 clk = ~clk;

   // simple core PC: advances one instruction per enable pulse
   always @(posedge clk) begin
      if (reset) pc <= 32'h0;
      else if (o_cpuEn) pc <= pc + 32'd4;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(int op, int arg, logic bp_en, logic [31:0] bp_addr,
                               logic [1:0] st, int p, int c, int c4, logic hit,
                               logic [31:0] exp_pc);
      vec_t v;
      v.op = op; v.arg = arg; v.bp_en = bp_en; v.bp_addr = bp_addr;
      v.st = st; v.pulses = p; v.cnt = c; v.cnt4 = c4; v.hit = hit; v.pc = exp_pc;
      return v;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
      if (o_cpuEn) pulses++;
      if (en4) pulses4++;
   endtask

   task automatic check(string name, int idx, logic [31:0] got, logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s [%0d]: got %0h, want %0h", name, idx, got, want);
      end
   endtask

   task automatic do_reset();
      i_tick = 1'b0; i_run = 1'b0; i_step = 1'b0; i_halt = 1'b0;
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      cycle();
   endtask

   task automatic apply_op(vec_t v);
      i_bpEn   = v.bp_en;
      i_bpAddr = v.bp_addr;
      case (v.op)
         OP_RESET: do_reset();
         OP_TICKS: begin
            for (int k = 0; k < v.arg; k++) begin
               i_tick = 1'b1;
               cycle();
               i_tick = 1'b0;
               repeat (4) cycle();
            end
         end
         default: begin
            i_run  = (v.op == OP_RUN)  || (v.op == OP_RUNSTEP);
            i_step = (v.op == OP_STEP) || (v.op == OP_RUNSTEP);
            i_halt = (v.op == OP_HALT);
            cycle();
            cycle();
            i_run = 1'b0; i_step = 1'b0; i_halt = 1'b0;
            cycle();
            cycle();
         end
      endcase
   endtask

   initial begin
      vec_t e;
      logic hw;
      reset = 1'b1; i_tick = 1'b0; i_run = 1'b0; i_step = 1'b0; i_halt = 1'b0;
      i_bpEn = 1'b0; i_bpAddr = 32'h0;

      // op, arg, bpEn, bpAddr | state, pulses, count, count4, bpHit, pc
      tbl.push_back(mk(OP_RESET,   0, 1'b0, 32'h0,  S_HALT, 0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_TICKS,  10, 1'b0, 32'h0,  S_HALT, 0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_RESET,   0, 1'b0, 32'h0,  S_HALT, 0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_STEP,    0, 1'b0, 32'h0,  S_STEP, 0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_TICKS,   3, 1'b0, 32'h0,  S_HALT, 1,  1,  1, 1'b0, 32'h4));
      tbl.push_back(mk(OP_RESET,   0, 1'b0, 32'h0,  S_HALT, 0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_RUN,     0, 1'b0, 32'h0,  S_RUN,  0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_TICKS,  10, 1'b0, 32'h0,  S_RUN, 10, 10, 10, 1'b0, 32'h28));
      tbl.push_back(mk(OP_HALT,    0, 1'b0, 32'h0,  S_HALT, 0, 10, 10, 1'b0, 32'h28));
      tbl.push_back(mk(OP_TICKS,   3, 1'b0, 32'h0,  S_HALT, 0, 10, 10, 1'b0, 32'h28));
      tbl.push_back(mk(OP_RESET,   0, 1'b1, 32'h10, S_HALT, 0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_RUN,     0, 1'b1, 32'h10, S_RUN,  0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_TICKS,   6, 1'b1, 32'h10, S_BRK,  4,  4,  4, 1'b1, 32'h10));
      tbl.push_back(mk(OP_RUN,     0, 1'b1, 32'h10, S_RUN,  0,  4,  4, 1'b0, 32'h10));
      tbl.push_back(mk(OP_TICKS,   1, 1'b1, 32'h10, S_RUN,  1,  5,  5, 1'b0, 32'h14));
      tbl.push_back(mk(OP_TICKS,   2, 1'b1, 32'h10, S_RUN,  2,  7,  7, 1'b0, 32'h1C));
      tbl.push_back(mk(OP_HALT,    0, 1'b1, 32'h10, S_HALT, 0,  7,  7, 1'b0, 32'h1C));
      tbl.push_back(mk(OP_RESET,   0, 1'b0, 32'h0,  S_HALT, 0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_RUNSTEP, 0, 1'b0, 32'h0,  S_RUN,  0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_HALT,    0, 1'b0, 32'h0,  S_HALT, 0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_RESET,   0, 1'b1, 32'h4,  S_HALT, 0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_STEP,    0, 1'b1, 32'h4,  S_STEP, 0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_TICKS,   1, 1'b1, 32'h4,  S_BRK,  1,  1,  1, 1'b1, 32'h4));
      tbl.push_back(mk(OP_HALT,    0, 1'b1, 32'h4,  S_BRK,  0,  1,  1, 1'b1, 32'h4));
      tbl.push_back(mk(OP_STEP,    0, 1'b1, 32'h4,  S_STEP, 0,  1,  1, 1'b0, 32'h4));
      tbl.push_back(mk(OP_TICKS,   2, 1'b1, 32'h4,  S_HALT, 1,  2,  2, 1'b0, 32'h8));
      tbl.push_back(mk(OP_RESET,   0, 1'b0, 32'h0,  S_HALT, 0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_RUN,     0, 1'b0, 32'h0,  S_RUN,  0,  0,  0, 1'b0, 32'h0));
      tbl.push_back(mk(OP_TICKS,  20, 1'b0, 32'h0,  S_RUN, 20, 20, 15, 1'b0, 32'h50));
      tbl.push_back(mk(OP_HALT,    0, 1'b0, 32'h0,  S_HALT, 0, 20, 15, 1'b0, 32'h50));
      tbl.push_back(mk(OP_RUN,     0, 1'b0, 32'h0,  S_RUN,  0, 20, 15, 1'b0, 32'h50));
      tbl.push_back(mk(OP_RUN,     0, 1'b0, 32'h0,  S_RUN,  0, 20, 15, 1'b0, 32'h50));
      tbl.push_back(mk(OP_STEP,    0, 1'b0, 32'h0,  S_RUN,  0, 20, 15, 1'b0, 32'h50));
      tbl.push_back(mk(OP_HALT,    0, 1'b0, 32'h0,  S_HALT, 0, 20, 15, 1'b0, 32'h50));
      tbl.push_back(mk(OP_HALT,    0, 1'b0, 32'h0,  S_HALT, 0, 20, 15, 1'b0, 32'h50));

      // reset state of both reset-mode variants
      cycle();
      cycle();
      check("rst_state",     -1, 32'(o_state),     32'(S_HALT));
      check("rst_halted",    -1, 32'(o_halted),    32'h1);
      check("rst_cpuen",     -1, 32'(o_cpuEn),     32'h0);
      check("rst_count",     -1, o_stepCount,      32'h0);
      check("rst_bphit",     -1, 32'(o_bpHit),     32'h0);
      check("rst_sr_state",  -1, 32'(state_sr),    32'(S_RUN));
      check("rst_sr_halted", -1, 32'(halted_sr),   32'h0);
      reset = 1'b0;
      cycle();

      for (int i = 0; i < tbl.size(); i++) begin
         exp_q.push_back(tbl[i]);
         pulses  = 0;
         pulses4 = 0;
         apply_op(tbl[i]);
         e  = exp_q.pop_front();
         hw = (e.st == S_HALT) || (e.st == S_BRK);
         check("state",   i, 32'(o_state),  32'(e.st));
         check("state4",  i, 32'(state4),   32'(e.st));
         check("halted",  i, 32'(o_halted), 32'(hw));
         check("bphit",   i, 32'(o_bpHit),  32'(e.hit));
         check("pulses",  i, 32'(pulses),   32'(e.pulses));
         check("pulses4", i, 32'(pulses4),  32'(e.pulses));
         check("count",   i, o_stepCount,   32'(e.cnt));
         check("count4",  i, 32'(cnt4),     32'(e.cnt4));
         check("pc",      i, pc,            e.pc);
      end

      // step: pulse one clock after the tick, exactly one clock wide
      i_bpEn = 1'b0; i_bpAddr = 32'h0;
      do_reset();
      i_step = 1'b1; cycle();
      i_step = 1'b0; cycle();
      check("step_entered", 100, 32'(o_state), 32'(S_STEP));
      i_tick = 1'b1; cycle();
      check("step_latency", 100, 32'(o_cpuEn), 32'h1);
      i_tick = 1'b0; cycle();
      check("step_width",   100, 32'(o_cpuEn), 32'h0);
      cycle();
      check("step_return",  100, 32'(o_state), 32'(S_HALT));

      // tick coincident with the run edge is ignored and not queued
      do_reset();
      i_run = 1'b1; i_tick = 1'b1; cycle();
      check("tick_on_run_edge", 101, 32'(o_cpuEn), 32'h0);
      check("run_entered",      101, 32'(o_state), 32'(S_RUN));
      i_run = 1'b0; i_tick = 1'b0; cycle();
      check("no_queued_tick",   101, 32'(o_cpuEn), 32'h0);

      // halt edge on the same clock as a breakpoint match wins
      i_bpEn = 1'b1; i_bpAddr = 32'h4;
      do_reset();
      i_run = 1'b1; cycle();
      i_run = 1'b0; cycle();
      i_tick = 1'b1; cycle();
      check("bp_pulse",      102, 32'(o_cpuEn), 32'h1);
      i_tick = 1'b0; cycle();
      check("bp_pc",         102, pc, 32'h4);
      i_halt = 1'b1; cycle();
      check("halt_beats_bp", 102, 32'(o_state), 32'(S_HALT));
      check("halt_no_bphit", 102, 32'(o_bpHit), 32'h0);
      i_halt = 1'b0; cycle();
      check("halt_stays",    102, 32'(o_state), 32'(S_HALT));

      // reset while a pulse is out
      i_bpEn = 1'b0;
      i_run = 1'b1; cycle();
      i_run = 1'b0; cycle();
      i_tick = 1'b1; cycle();
      check("pre_reset_pulse",  103, 32'(o_cpuEn), 32'h1);
      reset = 1'b1; cycle();
      check("reset_mid_pulse",  103, 32'(o_cpuEn), 32'h0);
      check("reset_count",      103, o_stepCount,  32'h0);
      check("reset_count4",     103, 32'(cnt4),    32'h0);
      check("reset_state",      103, 32'(o_state), 32'(S_HALT));
      reset = 1'b0; i_tick = 1'b0; cycle();
      check("post_reset_cpuen", 103, 32'(o_cpuEn), 32'h0);
      check("post_reset_state", 103, 32'(o_state), 32'(S_HALT));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
